// File: rtl/alarm_pkg.sv
// Shared definitions for the multi-zone intruder alarm controller:
// state encoding and a small helper used for parameter checks.
package alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } alarm_state_e;

    // Larger of two delays; used to size-check the delay timer.
    function automatic int max_delay(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/zone_debounce.sv
// One alarm zone: two-flop synchroniser for the raw asynchronous sensor,
// followed by a saturating run-length counter. The zone trips once the
// synchronised input has been high for DEB_CYCLES consecutive samples.
module zone_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    input  logic zone_en,
    output logic trip
);

    localparam int                DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_MAX = DEB_W'(DEB_CYCLES);

    logic             sync_q1;
    logic             sync_q2;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_next;

    // Next run length: count up while high, hold at DEB_MAX, drop to 0 on a low sample.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_next -- no latch is inferred.
        cnt_next = '0;
        if (sync_q2) begin
            cnt_next = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + DEB_W'(1);
        end
    end

    // Synchroniser, run-length counter and registered trip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            trip    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so sync_q2 takes the old sync_q1, forming a real two-stage chain.
            sync_q1 <= sensor;
            sync_q2 <= sync_q1;
            cnt_q   <= cnt_next;
            trip    <= zone_en && (cnt_next == DEB_MAX);
        end
    end

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone intruder alarm controller. Each zone is synchronised and
// debounced, then a single FSM handles arming with an exit delay, entry
// delay for ordinary zones, immediate alarm for instant zones, a latched
// alarm, and a sticky record of which enabled zones tripped while armed.
// Request priority within one cycle: disarm, then trip, then arm.
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ZONES     = 4,
    parameter int DEB_CYCLES  = 4,
    parameter int EXIT_DELAY  = 16,
    parameter int ENTRY_DELAY = 16,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] sensor_in,
    input  logic [N_ZONES-1:0] zone_en,
    input  logic [N_ZONES-1:0] instant_mask,
    input  logic               arm_req,
    input  logic               disarm_req,
    output logic [STATE_W-1:0] state_o,
    output logic               armed,
    output logic               warn,
    output logic               alarm,
    output logic [N_ZONES-1:0] zone_latch
);

    // Reject configurations the hardware cannot honour.
    if (N_ZONES < 1 || N_ZONES > 8) begin : g_bad_zones
        $error("alarm_zone_ctrl: N_ZONES must be in 1..8");
    end
    if (DEB_CYCLES < 1 || EXIT_DELAY < 1 || ENTRY_DELAY < 1) begin : g_bad_delay
        $error("alarm_zone_ctrl: DEB_CYCLES, EXIT_DELAY and ENTRY_DELAY must be >= 1");
    end
    if ((1 << CNT_W) <= max_delay(EXIT_DELAY, ENTRY_DELAY)) begin : g_bad_cnt_w
        $error("alarm_zone_ctrl: CNT_W too narrow for the exit/entry delays");
    end

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);

    logic [N_ZONES-1:0] trip;
    logic               any_trip;
    logic               any_instant;
    alarm_state_e       state_q;
    logic [CNT_W-1:0]   timer_q;

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        zone_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .sensor  (sensor_in[z]),
            .zone_en (zone_en[z]),
            .trip    (trip[z])
        );
    end

    assign any_trip    = |trip;
    assign any_instant = |(trip & instant_mask);

    // Alarm FSM with shared exit/entry countdown and the sticky zone record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DISARMED;
            timer_q    <= '0;
            zone_latch <= '0;
        end else begin
            if (state_q == ST_ARMED || state_q == ST_ENTRY || state_q == ST_ALARM) begin
                zone_latch <= zone_latch | trip;
            end

            unique case (state_q)
                ST_DISARMED: begin
                    if (!disarm_req && arm_req) begin
                        state_q    <= ST_EXIT;
                        timer_q    <= EXIT_LOAD;
                        zone_latch <= '0;
                    end
                end
                ST_EXIT: begin
                    if (disarm_req) begin
                        state_q <= ST_DISARMED;
                    end else if (timer_q == '0) begin
                        state_q <= ST_ARMED;
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (disarm_req) begin
                        state_q <= ST_DISARMED;
                    end else if (any_instant) begin
                        state_q <= ST_ALARM;
                    end else if (any_trip) begin
                        state_q <= ST_ENTRY;
                        timer_q <= ENTRY_LOAD;
                    end
                end
                ST_ENTRY: begin
                    if (disarm_req) begin
                        state_q <= ST_DISARMED;
                    end else if (any_instant || timer_q == '0) begin
                        state_q <= ST_ALARM;
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                ST_ALARM: begin
                    if (disarm_req) begin
                        state_q <= ST_DISARMED;
                    end
                end
                default: state_q <= ST_DISARMED;
            endcase
        end
    end

    // Status decoded from the state register alone, so it cannot glitch on input changes.
    always_comb begin
        state_o = state_q;
        armed   = (state_q == ST_ARMED) || (state_q == ST_ENTRY);
        warn    = (state_q == ST_EXIT)  || (state_q == ST_ENTRY);
        alarm   = (state_q == ST_ALARM);
    end

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Bench for alarm_zone_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all cross-checked every cycle against a
// behavioural model. A second instance (8 zones, 1-cycle debounce, 1-cycle
// exit) gets a short directed run.
module tb_alarm_zone_ctrl;

    localparam int NZ    = 4;
    localparam int DEB   = 4;
    localparam int EXT_D = 16;
    localparam int ENT_D = 16;

    localparam int S_DIS = 0, S_EXIT = 1, S_ARMED = 2, S_ENTRY = 3, S_ALARM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NZ-1:0] sensor_in, zone_en, instant_mask;
    logic          arm_req, disarm_req;
    logic [2:0]    state_o;
    logic          armed, warn, alarm;
    logic [NZ-1:0] zone_latch;

    logic [7:0]    b_sensor, b_en, b_inst;
    logic          b_arm, b_disarm;
    logic [2:0]    b_state;
    logic          b_armed, b_warn, b_alarm;
    logic [7:0]    b_latch;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alarm_zone_ctrl #(
        .N_ZONES(NZ), .DEB_CYCLES(DEB), .EXIT_DELAY(EXT_D), .ENTRY_DELAY(ENT_D), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor_in(sensor_in), .zone_en(zone_en),
        .instant_mask(instant_mask), .arm_req(arm_req), .disarm_req(disarm_req),
        .state_o(state_o), .armed(armed), .warn(warn), .alarm(alarm), .zone_latch(zone_latch)
    );

    alarm_zone_ctrl #(
        .N_ZONES(8), .DEB_CYCLES(1), .EXIT_DELAY(1), .ENTRY_DELAY(16), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sensor_in(b_sensor), .zone_en(b_en),
        .instant_mask(b_inst), .arm_req(b_arm), .disarm_req(b_disarm),
        .state_o(b_state), .armed(b_armed), .warn(b_warn), .alarm(b_alarm), .zone_latch(b_latch)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Zones: a zone is tripped after edge t when its sensor was sampled high
    // at edges t-DEB-1 .. t-2 and the zone is enabled at edge t.
    // Delays: tracked as the absolute edge number at which they expire.
    int            m_state;
    longint        m_cyc = 0;
    longint        m_deadline;
    logic [NZ-1:0] m_latch, m_trip;
    logic [NZ-1:0] m_hist [0:DEB+1];

    task automatic model_reset();
        m_state    = S_DIS;
        m_latch    = '0;
        m_trip     = '0;
        m_deadline = 0;
        for (int j = 0; j <= DEB + 1; j++) m_hist[j] = '0;
    endtask

    task automatic model_step();
        logic [NZ-1:0] t;
        logic [NZ-1:0] w;
        t = m_trip;
        m_cyc++;
        if (m_state == S_ARMED || m_state == S_ENTRY || m_state == S_ALARM) m_latch |= t;
        case (m_state)
            S_DIS:   if (!disarm_req && arm_req) begin
                         m_state = S_EXIT; m_deadline = m_cyc + EXT_D; m_latch = '0;
                     end
            S_EXIT:  if (disarm_req) m_state = S_DIS;
                     else if (m_cyc == m_deadline) m_state = S_ARMED;
            S_ARMED: if (disarm_req) m_state = S_DIS;
                     else if (|(t & instant_mask)) m_state = S_ALARM;
                     else if (|t) begin m_state = S_ENTRY; m_deadline = m_cyc + ENT_D; end
            S_ENTRY: if (disarm_req) m_state = S_DIS;
                     else if (|(t & instant_mask) || m_cyc == m_deadline) m_state = S_ALARM;
            default: if (disarm_req) m_state = S_DIS;
        endcase
        for (int j = DEB + 1; j >= 1; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = sensor_in;
        w = '1;
        for (int j = 2; j <= DEB + 1; j++) w &= m_hist[j];
        m_trip = w & zone_en;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(posedge clk);
        #1;
        check("state_o", state_o, m_state);
        check("armed", armed, (m_state == S_ARMED || m_state == S_ENTRY));
        check("warn", warn, (m_state == S_EXIT || m_state == S_ENTRY));
        check("alarm", alarm, (m_state == S_ALARM));
        check("zone_latch", zone_latch, m_latch);
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_a(input logic [2:0] want, output int k);
        k = 0;
        do begin @(negedge clk); k++; end while (state_o != want && k < 40);
        if (state_o != want) k = -1;
    endtask

    task automatic wait_b(input logic [2:0] want, output int k);
        k = 0;
        do begin @(negedge clk); k++; end while (b_state != want && k < 40);
        if (b_state != want) k = -1;
    endtask

    task automatic pulse_arm();
        arm_req = 1'b1; @(negedge clk); arm_req = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm_req = 1'b1; @(negedge clk); disarm_req = 1'b0;
    endtask

    task automatic arm_to_armed();
        pulse_arm();
        repeat (EXT_D) @(negedge clk);
        check("armed_after_exit", state_o, S_ARMED);
    endtask

    initial begin
        int k, wc;
        bit saw_entry;
        sensor_in = '0; zone_en = '1; instant_mask = '0; arm_req = 0; disarm_req = 0;
        b_sensor = '0; b_en = '1; b_inst = '0; b_arm = 0; b_disarm = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_state", state_o, S_DIS);
        check("reset_alarm", alarm, 0);
        check("reset_latch", zone_latch, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Small configuration: ARMED one cycle after arm, trip after 3 edges
        b_arm = 1; @(negedge clk); b_arm = 0;
        check("b_exit_state", b_state, S_EXIT);
        check("b_exit_warn", b_warn, 1);
        @(negedge clk);
        check("b_armed_state", b_state, S_ARMED);
        check("b_armed_flag", b_armed, 1);
        check("b_armed_warn", b_warn, 0);
        b_sensor[7] = 1'b1;
        wait_b(S_ENTRY, k);
        check("b_entry_latency", k, 4);
        check("b_latch", b_latch, 8'h80);
        b_disarm = 1; @(negedge clk); b_disarm = 0; b_sensor = '0;
        check("b_disarmed", b_state, S_DIS);

        // Exit delay: warn for exactly EXIT_DELAY cycles
        pulse_arm();
        wc = 0;
        for (int i = 0; i < 20; i++) begin
            if (warn) wc++;
            @(negedge clk);
        end
        check("exit_warn_cycles", wc, 16);
        check("exit_done_state", state_o, S_ARMED);
        check("exit_done_armed", armed, 1);
        check("exit_done_warn", warn, 0);

        // Ordinary zone: ENTRY 7 edges after rise, ALARM 16 later, latched
        sensor_in[1] = 1'b1;
        wait_a(S_ENTRY, k);
        check("entry_latency", k, 7);
        wait_a(S_ALARM, k);
        check("entry_duration", k, 16);
        check("latch_zone1", zone_latch, 4'b0010);
        sensor_in = '0;
        repeat (10) @(negedge clk);
        check("alarm_latched", alarm, 1);

        pulse_disarm();
        check("disarm_state", state_o, S_DIS);
        check("disarm_alarm", alarm, 0);
        check("latch_kept_after_disarm", zone_latch, 4'b0010);

        // Instant zone: 6-cycle pulse -> ALARM on edge 7, no ENTRY
        arm_to_armed();
        instant_mask = 4'b0001;
        sensor_in[0] = 1'b1;
        k = 0; saw_entry = 0;
        while (k < 20) begin
            @(negedge clk); k++;
            if (k == 6) sensor_in[0] = 1'b0;
            if (state_o == S_ENTRY) saw_entry = 1;
            if (alarm) break;
        end
        check("instant_latency", k, 7);
        check("instant_no_entry", saw_entry, 0);
        pulse_disarm();
        check("instant_disarm_state", state_o, S_DIS);
        check("instant_disarm_alarm", alarm, 0);
        check("instant_latch_kept", zone_latch, 4'b0001);
        pulse_arm();
        check("latch_cleared_on_arm", zone_latch, 0);
        repeat (EXT_D) @(negedge clk);
        instant_mask = '0;

        // Bounce rejection: 3 high, 1 low, 3 high
        for (int i = 0; i < 7; i++) begin
            sensor_in[2] = (i != 3);
            @(negedge clk);
        end
        sensor_in[2] = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_rejected", state_o, S_ARMED);
        check("bounce_latch", zone_latch, 0);

        // Bypassed zone held high has no effect
        zone_en = 4'b0111;
        sensor_in[3] = 1'b1;
        repeat (12) @(negedge clk);
        check("disabled_zone_ignored", state_o, S_ARMED);
        sensor_in[3] = 1'b0;
        repeat (6) @(negedge clk);
        zone_en = '1;
        repeat (2) @(negedge clk);

        // ENTRY with 5 cycles left: disarm and a new instant trip together
        sensor_in[1] = 1'b1;
        wait_a(S_ENTRY, k);
        check("entry_latency2", k, 7);
        repeat (4) @(negedge clk);
        instant_mask = 4'b0001;
        sensor_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        disarm_req = 1'b1; @(negedge clk); disarm_req = 1'b0;
        check("disarm_beats_trip", state_o, S_DIS);
        check("disarm_beats_trip_alarm", alarm, 0);
        sensor_in = '0;
        repeat (6) @(negedge clk);

        // Asynchronous reset in the middle of ALARM
        instant_mask = 4'b0010;
        arm_to_armed();
        sensor_in[1] = 1'b1;
        wait_a(S_ALARM, k);
        check("instant_alarm_before_reset", k, 7);
        sensor_in = '0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_state", state_o, S_DIS);
        check("async_reset_alarm", alarm, 0);
        check("async_reset_latch", zone_latch, 0);
        @(negedge clk);
        rst_n = 1'b1;
        instant_mask = '0;
        repeat (3) @(negedge clk);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int z = 0; z < NZ; z++)
                if ($urandom_range(0, 9) == 0) sensor_in[z] = ~sensor_in[z];
            if ($urandom_range(0, 99) == 0)  zone_en = NZ'($urandom);
            if ($urandom_range(0, 199) == 0) instant_mask = NZ'($urandom);
            arm_req    = ($urandom_range(0, 19) == 0);
            disarm_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        sensor_in = '0; arm_req = 0; disarm_req = 0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
